// File: rtl/mod_share_arbiter.sv
// Round-robin sequencer that shares one mod-509 reduction unit among N_REQ lane requesters.
// Define MOD_ARB_TIMEOUT_EN to abandon a WAIT after TIMEOUT cycles with an error response.
module mod_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 18,
    parameter int RW      = 9,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DW-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       mod_rdy,
    output logic [DW-1:0]              mod_dividend,
    input  logic [RW-1:0]              mod_remainder,
    input  logic                       mod_out_valid,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [RW-1:0]              rsp_data,
    output logic [$clog2(N_REQ)-1:0]   rsp_tag,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int TW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [TW-1:0]       ptr_q;
    logic [TW-1:0]       ptr_d;
    logic [DW-1:0]       div_q;
    logic [TW-1:0]       tag_q;
    logic                mod_rdy_q;
    logic                rsp_valid_q;
    logic [RW-1:0]       rsp_data_q;
    logic [TW-1:0]       rsp_tag_q;
    logic                busy_q;

`ifdef MOD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]       cnt_q;
    logic                rsp_err_q;
`endif

    logic [2*N_REQ-1:0]  dbl_req;
    logic [N_REQ-1:0]    rot_req;
    logic                grant_any;
    logic [TW-1:0]       grant_off;
    logic [TW:0]         grant_sum;
    logic [TW-1:0]       grant_idx;
    logic [DW-1:0]       grant_data;

    // Rotate the request vector so bit 0 is the lane at the pointer; the lowest set bit wins.
    always_comb begin
        dbl_req   = {req_valid, req_valid} >> ptr_q;
        rot_req   = dbl_req[N_REQ-1:0];
        grant_any = |rot_req;
        grant_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                grant_off = TW'(j);
            end
        end
        grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
        if (grant_sum >= (TW+1)'(N_REQ)) begin
            grant_idx = TW'(grant_sum - (TW+1)'(N_REQ));
        end else begin
            grant_idx = TW'(grant_sum);
        end
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == TW'(i)) begin
                grant_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && grant_any && !rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                req_ready[i] = (grant_idx == TW'(i));
            end
        end
    end

    assign ptr_d = (tag_q == TW'(N_REQ - 1)) ? '0 : tag_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            div_q       <= '0;
            tag_q       <= '0;
            mod_rdy_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            busy_q      <= 1'b0;
`ifdef MOD_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            mod_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        div_q     <= grant_data;
                        tag_q     <= grant_idx;
                        mod_rdy_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MOD_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mod_out_valid) begin
                        rsp_data_q  <= mod_remainder;
                        rsp_tag_q   <= tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`ifdef MOD_ARB_TIMEOUT_EN
                    // This is the TIMEOUT-th WAIT cycle without a result.
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_tag_q   <= tag_q;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef MOD_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        ptr_q       <= ptr_d;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mod_rdy      = mod_rdy_q;
    assign mod_dividend = div_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign busy         = busy_q;
`ifdef MOD_ARB_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule
